// File: rtl/ram_stream_reader_pkg.sv
// Shared RAM package: default geometry of the RAM words and the reader state
// encoding. The dual-port RAM and the stream reader both import this so the
// data/address widths stay in one place.
package ram_stream_reader_pkg;

    localparam int default_data_width = 8;
    localparam int default_addr_width = 4;
    localparam int default_depth      = 16;

    // Reader control states: wait for a request, push words out, signal completion.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } reader_state_t;

endpackage : ram_stream_reader_pkg

// File: rtl/ram_stream_reader_if.sv
// Bundle of the request, RAM read-port and output stream signals of the
// RAM stream reader. The reader itself uses the slave view; whoever requests
// bursts, models the RAM and consumes the stream uses the master view.
interface ram_stream_reader_if
    import ram_stream_reader_pkg::*;
#(
    parameter int data_width = default_data_width,
    parameter int addr_width = default_addr_width
);

    // burst request
    logic                  start;
    logic [addr_width-1:0] base_addr;
    logic [addr_width:0]   length;

    // RAM read port (ram_data is combinational for ram_addr)
    logic                  ram_en;
    logic [addr_width-1:0] ram_addr;
    logic [data_width-1:0] ram_data;

    // output stream
    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    // status
    logic                  busy;
    logic                  done;

    modport master (
        output start,
        output base_addr,
        output length,
        input  ram_en,
        input  ram_addr,
        output ram_data,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  base_addr,
        input  length,
        output ram_en,
        output ram_addr,
        input  ram_data,
        output out_data,
        output out_valid,
        input  out_ready,
        output busy,
        output done
    );

endinterface : ram_stream_reader_if

// File: rtl/ram_stream_reader_stream_out_reg.sv
// Output holding register of the stream reader. Holds one word with its valid
// flag; a load always wins (it both replaces the word and keeps valid high),
// otherwise a handshake empties the register.
module stream_out_reg #(
    parameter int data_width = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [data_width-1:0] load_data,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid
);

    // Capture a new word on load, drop valid when the word is taken and nothing replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : stream_out_reg

// File: rtl/ram_stream_reader.sv
// RAM stream reader: on a start request, reads `length` consecutive RAM words
// beginning at `base_addr` (wrapping modulo the RAM depth) and presents them
// on a valid/ready stream, one word per cycle while the consumer keeps up.
// The FSM and the address/word counters live here; the output word register
// is the stream_out_reg sub-module.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int data_width = default_data_width,
    parameter int addr_width = default_addr_width,
    parameter int depth      = default_depth
)(
    input  logic              clk,
    input  logic              rst,
    ram_stream_reader_if.slave bus
);

    localparam logic [addr_width-1:0] last_addr = addr_width'(depth - 1);
    localparam logic [addr_width-1:0] addr_one  = addr_width'(1);
    localparam logic [addr_width:0]   count_one = (addr_width + 1)'(1);

    reader_state_t         state_q;
    reader_state_t         state_d;
    logic                  start_accept;
    logic                  slot_free;
    logic                  load;
    logic [addr_width-1:0] ptr_q;
    logic [addr_width-1:0] ptr_next;
    logic [addr_width-1:0] addr_hold_q;
    logic [addr_width:0]   remaining_q;
    logic                  out_valid;

    // The output register can take a new word when it is empty or its word leaves this cycle.
    assign slot_free = !out_valid || bus.out_ready;

    // Fetch the word at ptr whenever streaming, words are left and the output slot frees up.
    assign load = (state_q == STREAM) && (remaining_q != '0) && slot_free;

    // Address after ptr, wrapping from the last RAM word back to word 0.
    assign ptr_next = (ptr_q == last_addr) ? '0 : ptr_q + addr_one;

    // Next-state logic; start is only honoured in IDLE, a zero-length burst goes straight to DONE.
    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_accept = 1'b1;
                    state_d      = (bus.length == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if ((remaining_q == '0) && slot_free) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst pointer and word counter: loaded on an accepted start, stepped on each fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            remaining_q <= '0;
        end else if (start_accept) begin
            ptr_q       <= bus.base_addr;
            remaining_q <= bus.length;
        end else if (load) begin
            ptr_q       <= ptr_next;
            remaining_q <= remaining_q - count_one;
        end
    end

    // Remember the last address driven while streaming so the port address stays put outside STREAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_q <= '0;
        end else if (state_q == STREAM) begin
            addr_hold_q <= ptr_q;
        end
    end

    stream_out_reg #(
        .data_width (data_width)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (bus.ram_data),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_valid (out_valid)
    );

    assign bus.out_valid = out_valid;
    assign bus.ram_en    = (state_q == STREAM);
    assign bus.ram_addr  = (state_q == STREAM) ? ptr_q : addr_hold_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule : ram_stream_reader
